// File: rtl/ft_pkg.sv
// Shared types and helpers for the checkpoint rollback sequencer.
package ft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_SETPC,
    ST_DONE,
    ST_FAIL
  } rec_state_e;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam logic [31:0] PC_ADDR_DEF  = 32'd32;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] base,
                                                    input logic [31:0] word);
    return base + (word << 2);
  endfunction

endpackage

// File: rtl/ft_recovery_ctrl.sv
// Rollback sequencer: on a lockstep error, halts the core, reads x1..x(N-1) and the PC
// back from checkpoint memory, replays them into the core and releases it.
//
// state | meaning
// IDLE  | core running, watching error_i
// REQ   | read request for the current word, held until granted
// WAIT  | request granted, waiting for rvalid (retry on mem_err_i)
// WRITE | one-cycle register file write of the latched word
// SETPC | one-cycle PC load of the latched word
// DONE  | one-cycle completion pulse, core still halted
// FAIL  | retries exhausted; core stays halted until reset
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter logic [31:0] PC_ADDR   = PC_ADDR_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        error_i,
  output logic        halt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        pc_set_o,
  output logic [31:0] pc_o
);

  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  rec_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                pc_phase_q;
  logic [4:0]          rf_waddr_q;
  logic [31:0]         rf_wdata_q;
  logic [31:0]         pc_q;
  logic                last_reg;
  logic                retry_ok;
  logic [31:0]         word;

  assign last_reg = (idx_q == IDX_W'(NUM_REGS - 1));
  assign retry_ok = (retry_q < RETRY_W'(MAX_RETRY));
  assign word     = pc_phase_q ? PC_ADDR : 32'(idx_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= IDX_W'(1);
      retry_q    <= '0;
      pc_phase_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (error_i) begin
            idx_q      <= IDX_W'(1);
            retry_q    <= '0;
            pc_phase_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              if (retry_ok) retry_q <= retry_q + RETRY_W'(1);
            end else if (pc_phase_q) begin
              pc_q <= mem_rdata_i;
            end else begin
              rf_wdata_q <= mem_rdata_i;
              rf_waddr_q <= 5'(idx_q);
            end
          end
        end
        ST_WRITE: begin
          retry_q <= '0;
          if (last_reg) pc_phase_q <= 1'b1;
          else          idx_q      <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (error_i) state_d = ST_REQ;
      ST_REQ:   if (mem_gnt_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (mem_err_i)       state_d = retry_ok ? ST_REQ : ST_FAIL;
          else if (pc_phase_q) state_d = ST_SETPC;
          else                 state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_REQ;
      ST_SETPC: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from state; data comes from the registered latches.
  always_comb begin
    halt_o     = (state_q != ST_IDLE);
    busy_o     = (state_q != ST_IDLE) && (state_q != ST_FAIL);
    done_o     = (state_q == ST_DONE);
    fail_o     = (state_q == ST_FAIL);
    mem_req_o  = (state_q == ST_REQ);
    mem_addr_o = '0;
    if (state_q == ST_REQ) mem_addr_o = word_to_byte_addr(BASE_ADDR, word);
    rf_we_o    = (state_q == ST_WRITE);
    rf_waddr_o = rf_waddr_q;
    rf_wdata_o = rf_wdata_q;
    pc_set_o   = (state_q == ST_SETPC);
    pc_o       = pc_q;
  end

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Scoreboard bench for ft_recovery_ctrl: a memory responder and a monitor check the
// DUT against expectations queued by the directed stimulus.
module tb_ft_recovery_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        error_i;
  logic        halt_o, busy_o, done_o, fail_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_rdata_i;
  logic        rf_we_o, pc_set_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, pc_o;

  always #5 clk_i = ~clk_i;

  ft_recovery_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .error_i(error_i),
    .halt_o(halt_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pc_set_o(pc_set_o), .pc_o(pc_o)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } rf_exp_t;

  rf_exp_t     rf_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem [0:32];

  int checks = 0;
  int passes = 0;

  int stall_word = -1, stall_left = 0, stall_seen = 0;
  int err_word = -1, err_left = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Memory responder: gnt in the request cycle, rvalid one cycle later.
  initial begin
    bit pend = 0;
    int pend_word = 0;
    int w;
    logic [31:0] e;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
      if (rst_i) begin
        pend = 0;
      end else begin
        if (pend) begin
          mem_rvalid_i = 1;
          mem_rdata_i  = mem[pend_word];
          if (pend_word == err_word && err_left > 0) begin
            mem_err_i   = 1;
            mem_rdata_i = 32'hDEAD_BEEF;
            err_left--;
          end
          pend = 0;
        end
        if (mem_req_o) begin
          w = int'(mem_addr_o >> 2);
          if (w == stall_word) stall_seen++;
          if (w == stall_word && stall_left > 0) begin
            stall_left--;
          end else begin
            mem_gnt_i = 1;
            pend = 1;
            pend_word = (w <= 32) ? w : 0;
            if (addr_q.size() == 0) begin
              checks++;
              $display("FAIL addr_unexpected: got %h expected none", mem_addr_o);
            end else begin
              e = addr_q.pop_front();
              chk("mem_addr", mem_addr_o, e);
            end
          end
        end
      end
    end
  end

  // Strobe monitor.
  initial begin
    rf_exp_t re;
    logic [31:0] pe;
    forever begin
      @(negedge clk_i);
      if (rf_we_o) begin
        if (rf_q.size() == 0) begin
          checks++;
          $display("FAIL rf_unexpected: got x%0d=%h expected none", rf_waddr_o, rf_wdata_o);
        end else begin
          re = rf_q.pop_front();
          chk("rf_waddr", {27'b0, rf_waddr_o}, {27'b0, re.a});
          chk("rf_wdata", rf_wdata_o, re.d);
        end
      end
      if (pc_set_o) begin
        if (pc_q.size() == 0) begin
          checks++;
          $display("FAIL pc_unexpected: got %h expected none", pc_o);
        end else begin
          pe = pc_q.pop_front();
          chk("pc", pc_o, pe);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_recovery(input int ew, input int en, input bit to_fail);
    rf_exp_t r;
    for (int i = 1; i < 32; i++) begin
      int n;
      n = (i == ew) ? en : 0;
      if (to_fail && i == ew) begin
        for (int k = 0; k < n; k++) addr_q.push_back(32'(i) << 2);
        return;
      end
      for (int k = 0; k <= n; k++) addr_q.push_back(32'(i) << 2);
      r.a = 5'(i);
      r.d = mem[i];
      rf_q.push_back(r);
    end
    addr_q.push_back(32'h80);
    pc_q.push_back(mem[32]);
  endtask

  task automatic kick();
    error_i = 1;
    @(posedge clk_i);
  endtask

  task automatic wait_done(input string name, input int exp, input bit inject);
    int done_at = 0, halt_cnt = 0, low_at = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk_i);
      error_i = 0;
      if (!halt_o) begin
        low_at = k;
        break;
      end
      halt_cnt++;
      if (done_o) done_at = k;
      if (inject && ((rf_we_o && rf_waddr_o == 5'd12) || done_o)) error_i = 1;
    end
    chk({name, "_done_cycle"}, 32'(done_at), 32'(exp));
    chk({name, "_halt_cycles"}, 32'(halt_cnt), 32'(exp));
    chk({name, "_halt_low_cycle"}, 32'(low_at), 32'(exp + 1));
  endtask

  task automatic check_drained(input string name);
    chk({name, "_rf_left"}, 32'(rf_q.size()), 32'd0);
    chk({name, "_pc_left"}, 32'(pc_q.size()), 32'd0);
    chk({name, "_addr_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_halt"}, {31'b0, halt_o}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({name, "_done"}, {31'b0, done_o}, 32'd0);
    chk({name, "_fail"}, {31'b0, fail_o}, 32'd0);
    chk({name, "_req"}, {31'b0, mem_req_o}, 32'd0);
    chk({name, "_addr"}, mem_addr_o, 32'd0);
    chk({name, "_rf_we"}, {31'b0, rf_we_o}, 32'd0);
    chk({name, "_pc_set"}, {31'b0, pc_set_o}, 32'd0);
  endtask

  initial begin
    int fail_at;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1111_1111 * 32'(i);
    mem[32] = 32'h0000_0180;
    rst_i = 1;
    error_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_outputs("reset");
    chk("reset_waddr", {27'b0, rf_waddr_o}, 32'd0);
    chk("reset_wdata", rf_wdata_o, 32'd0);
    chk("reset_pc", pc_o, 32'd0);
    rst_i = 0;

    // Nominal zero-wait recovery.
    @(negedge clk_i);
    push_recovery(-1, 0, 0);
    kick();
    wait_done("nominal", 97, 0);
    check_drained("nominal");
    chk("nominal_pc_hold", pc_o, 32'h180);

    // Gnt withheld two cycles on x5.
    @(negedge clk_i);
    stall_word = 5; stall_left = 2; stall_seen = 0;
    push_recovery(-1, 0, 0);
    kick();
    wait_done("stall", 99, 0);
    check_drained("stall");
    chk("stall_req_cycles", 32'(stall_seen), 32'd3);
    stall_word = -1;

    // One read error on x7.
    @(negedge clk_i);
    err_word = 7; err_left = 1;
    push_recovery(7, 1, 0);
    kick();
    wait_done("retry", 99, 0);
    check_drained("retry");
    err_word = -1;

    // error_i during x12 and DONE is ignored; error_i right after DONE restarts.
    @(negedge clk_i);
    push_recovery(-1, 0, 0);
    push_recovery(-1, 0, 0);
    kick();
    wait_done("ignore", 97, 1);
    kick();
    wait_done("restart", 97, 0);
    check_drained("restart");

    // Reset held for two edges while in REQ.
    @(negedge clk_i);
    error_i = 1;
    @(posedge clk_i);
    #1;
    chk("rstmid_req_before", {31'b0, mem_req_o}, 32'd1);
    rst_i = 1;
    error_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    check_idle_outputs("rstmid");
    repeat (4) @(negedge clk_i);
    check_drained("rstmid");

    // Four consecutive errors on x3 exhaust the retries.
    @(negedge clk_i);
    err_word = 3; err_left = 4;
    push_recovery(3, 4, 1);
    kick();
    fail_at = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_i);
      error_i = 0;
      if (fail_o) begin
        fail_at = k;
        break;
      end
    end
    chk("fail_cycle", 32'(fail_at), 32'd15);
    chk("fail_halt", {31'b0, halt_o}, 32'd1);
    chk("fail_busy", {31'b0, busy_o}, 32'd0);
    chk("fail_req", {31'b0, mem_req_o}, 32'd0);
    error_i = 1;
    @(negedge clk_i);
    error_i = 0;
    repeat (8) @(negedge clk_i);
    chk("fail_sticky", {31'b0, fail_o}, 32'd1);
    chk("fail_halt_sticky", {31'b0, halt_o}, 32'd1);
    chk("fail_done", {31'b0, done_o}, 32'd0);
    check_drained("fail");
    err_word = -1;
    rst_i = 1;
    @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    check_idle_outputs("fail_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ft_recovery_ctrl.md
Name: ft_recovery_ctrl

Overview:
- Rollback sequencer for the fault-tolerant checkpoint memory.
- When the lockstep comparator flags an error, it halts the core and reads back checkpointed registers x1..x(NUM_REGS-1) and the PC over the memory req/gnt/rvalid interface.
- It replays the registers into the core register file, restores the PC, then releases the core.
- Sits between the error detector, the checkpoint memory read port and the core's rf/PC write ports.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never restored.
- PC_ADDR, 32, word index of the PC slot in checkpoint memory.
- BASE_ADDR, 32'h0, byte base address of the checkpoint memory.
- MAX_RETRY, 3, number of reissues allowed per word after mem_err_i.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- error_i  in  1  error detected; sampled only in IDLE.
- halt_o  out  1  stall the core; high whenever state != IDLE.
- busy_o  out  1  same as halt_o, excluding the FAIL state.
- done_o  out  1  one-cycle pulse when recovery completes.
- fail_o  out  1  sticky; retries exhausted.
- mem_req_o  out  1  read request.
- mem_gnt_i  in  1  request accepted.
- mem_addr_o  out  32  byte address.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.
- mem_err_i  in  1  read error, qualified by mem_rvalid_i.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  5  register file write index.
- rf_wdata_o  out  32  register file write data.
- pc_set_o  out  1  one-cycle PC load strobe.
- pc_o  out  32  restored PC.

Behaviour:
- Reset (rst_i high at posedge):
  - state=IDLE; idx=1; retry=0.
  - All outputs 0, including fail_o.
  - Reset mid-recovery aborts immediately; no further rf/pc strobes are issued.
- States: IDLE, REQ, WAIT, WRITE, SETPC, DONE, FAIL.
- IDLE:
  - error_i=1 → REQ, with idx=1 and retry=0.
  - error_i is ignored in every other state.
- REQ:
  - mem_req_o=1.
  - mem_addr_o = BASE_ADDR + (word<<2), where word = idx for registers and PC_ADDR during the PC phase.
  - Address and req are held stable until mem_gnt_i. On gnt → WAIT.
  - At most one request is outstanding.
- WAIT:
  - mem_req_o=0; wait any number of cycles for mem_rvalid_i.
  - rvalid with err, retry<MAX_RETRY: retry++ → REQ with the same address.
  - rvalid with err, retry==MAX_RETRY → FAIL.
  - rvalid without err, register phase: latch data → WRITE.
  - rvalid without err, PC phase: latch data → SETPC.
- WRITE:
  - rf_we_o=1 for exactly one cycle, with rf_waddr_o=idx[4:0] and rf_wdata_o=latched data.
  - retry=0.
  - idx==NUM_REGS-1 → enter PC phase, then REQ. Otherwise idx++ → REQ.
- SETPC: pc_set_o=1 for one cycle with pc_o=latched data → DONE.
- DONE: done_o=1 for one cycle → IDLE. halt_o is still high in DONE.
- FAIL:
  - fail_o=1 and halt_o=1; busy_o=0.
  - No strobes are issued.
  - The only exit is rst_i.
- Registered/combinational split:
  - rf_* and pc_* outputs are registered (data from the latch).
  - mem_req_o and halt_o are decoded from state.
- Timing with a zero-wait memory (gnt in the same cycle as req, rvalid one cycle later):
  - Each register takes 3 cycles; the PC takes 3; DONE takes 1.
  - error_i is sampled at edge 0.
  - halt_o is high in cycles 1..97; done_o is in cycle 97; halt_o is low in cycle 98.
- Each gnt wait cycle or extra rvalid wait cycle adds exactly 1 cycle. Each retry adds 2 cycles.
- rf_wdata_o and pc_o hold their last value when not strobed. Their reset value is 0.

Decomposition:
- Package ft_pkg holds:
  - rec_state_e enum.
  - NUM_REGS_DEF and PC_ADDR_DEF constants.
  - The function word_to_byte_addr().
- No sub-module is warranted: the FSM, idx/retry counters and data latch form a single module (~180 lines).

Test Plan:
- Reset: rst_i held 2 cycles during REQ → next cycle all outputs 0, state IDLE, mem_req_o=0.
- Nominal recovery, zero-wait memory with mem[i]=32'h1111_1111*i and mem[32]=32'h0000_0180; pulse error_i:
  - 31 rf writes in order x1..x31 with the matching data.
  - Addresses 0x04..0x7C, then 0x80.
  - pc_set_o with pc_o=0x180.
  - done_o in cycle 97; halt_o high for exactly 97 cycles.
- Gnt stall: memory withholds gnt 2 cycles on x5 → mem_addr_o=0x14 and mem_req_o stable for 3 cycles; done_o in cycle 99.
- Single mem_err on x7 → address 0x1C is reissued; no rf write for the errored beat; x7 is written once with the correct data; done_o in cycle 99.
- Four consecutive mem_err on x3 (MAX_RETRY=3):
  - fail_o=1, halt_o=1, busy_o=0.
  - No rf writes after x2; no pc_set_o.
  - State persists until rst_i.
- error_i pulsed at x12 and again in the DONE cycle → both ignored. error_i in the cycle after DONE starts a new recovery at address 0x04.
